// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - shared iterative multiply/divide unit, one bit per cycle
// Signed operands are reduced to magnitudes on accept; signs are restored in FIX.
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [1:0]         op_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               busy_o,
   output logic               div_zero_o
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   localparam logic [WIDTH-1:0] LAST = WIDTH'(WIDTH - 1);

   state_t               state, state_nxt;
   logic [WIDTH-1:0]     cnt;
   logic                 div_q;
   logic                 neg_q, neg_r;
   logic [WIDTH-1:0]     b_q;
   logic [2*WIDTH-1:0]   acc;

   logic                 is_div, is_signed, sign1, sign2;
   logic [WIDTH-1:0]     mag1, mag2;
   logic                 accept, mul_zero, div_by_zero;
   logic [WIDTH-1:0]     hi, lo, hi_fix, lo_fix;
   logic [WIDTH:0]       sum, shifted, trial;
   logic [2*WIDTH-1:0]   mul_step, div_step, fix_val;

   assign is_div      = op_i[1];
   assign is_signed   = ~op_i[0];
   assign sign1       = is_signed & opdata1_i[WIDTH-1];
   assign sign2       = is_signed & opdata2_i[WIDTH-1];
   assign mag1        = sign1 ? -opdata1_i : opdata1_i;
   assign mag2        = sign2 ? -opdata2_i : opdata2_i;
   assign accept      = start_i & ~annul_i;
   assign mul_zero    = ~is_div & ((opdata1_i == '0) | (opdata2_i == '0));
   assign div_by_zero = is_div & (opdata2_i == '0);

   assign hi = acc[2*WIDTH-1:WIDTH];
   assign lo = acc[WIDTH-1:0];

   // Multiply: lo holds the multiplier and drains out as the product shifts in from the top.
   assign sum      = {1'b0, hi} + {1'b0, b_q};
   assign mul_step = lo[0] ? {sum, lo[WIDTH-1:1]} : {1'b0, hi, lo[WIDTH-1:1]};

   // Divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
   assign shifted  = {hi, lo[WIDTH-1]};
   assign trial    = shifted - {1'b0, b_q};
   assign div_step = trial[WIDTH] ? {shifted[WIDTH-1:0], lo[WIDTH-2:0], 1'b0}
                                  : {trial[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};

   assign hi_fix  = neg_r ? -hi : hi;
   assign lo_fix  = neg_q ? -lo : lo;
   assign fix_val = div_q ? {hi_fix, lo_fix} : (neg_q ? -acc : acc);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = (mul_zero | div_by_zero) ? DONE : CALC;
         CALC: begin
            if (annul_i)          state_nxt = IDLE;
            else if (cnt == LAST) state_nxt = FIX;
         end
         FIX:  state_nxt = annul_i ? IDLE : DONE;
         DONE: if (annul_i | ~start_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         div_q      <= 1'b0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         b_q        <= '0;
         acc        <= '0;
         result_o   <= '0;
         div_zero_o <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (accept) begin
               cnt   <= '0;
               div_q <= is_div;
               neg_q <= sign1 ^ sign2;
               neg_r <= sign1;
               b_q   <= is_div ? mag2 : mag1;
               acc   <= {{WIDTH{1'b0}}, is_div ? mag1 : mag2};
               if (mul_zero) begin
                  result_o <= '0;
               end else if (div_by_zero) begin
                  result_o   <= {opdata1_i, {WIDTH{1'b1}}};
                  div_zero_o <= 1'b1;
               end
            end
            CALC: begin
               acc <= div_q ? div_step : mul_step;
               cnt <= cnt + 1'b1;
            end
            FIX: if (!annul_i) begin
               result_o   <= fix_val;
               div_zero_o <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign busy_o  = (state == CALC) || (state == FIX);
   assign ready_o = (state == DONE);

endmodule
